// File: rtl/router_destin_port_if.sv
// router_destin_port_if: write-side and destination-side signals of one router output port
interface router_destin_port_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             full;
  logic             soft_reset;
  logic             pkt_done;
  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, valid_out, full, soft_reset, pkt_done
  );
  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, valid_out, full, soft_reset, pkt_done
  );
endinterface

// File: rtl/router_destin_port.sv
// router_destin_port: per-destination FIFO with packet tracking and unread-timeout self flush
module router_destin_port #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input logic                clk,
  input logic                resetn,
  router_destin_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [TW-1:0]    to_q, to_d;
  logic             sr_q, sr_d, pd_q, pd_d;
  logic             empty, full, we, re, stall;
  logic [WIDTH:0]   ent;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // a pending flush swallows any access in the same cycle
  assign we    = bus.write_enb && !full && !sr_q;
  assign re    = bus.read_enb && !empty && !sr_q;
  assign stall = !empty && !bus.read_enb;
  assign ent   = mem[rptr_q[AW-1:0]];
  assign bus.data_out   = dout_q;
  assign bus.valid_out  = !empty;
  assign bus.full       = full;
  assign bus.soft_reset = sr_q;
  assign bus.pkt_done   = pd_q;
  // next state: pointers, read data, packet length tracking, unread timeout
  always_comb begin
    wptr_d = we ? wptr_q + 1'b1 : wptr_q;
    rptr_d = re ? rptr_q + 1'b1 : rptr_q;
    dout_d = re ? ent[WIDTH-1:0] : dout_q;
    cnt_d  = !re ? cnt_q :
             ent[WIDTH] ? 7'(ent[WIDTH-1:2]) + 7'd1 :
             (cnt_q != 7'd0) ? cnt_q - 7'd1 : cnt_q;
    pd_d   = re && !ent[WIDTH] && cnt_q == 7'd1;
    to_d   = stall ? to_q + 1'b1 : '0;
    sr_d   = stall && to_d == TW'(TIMEOUT - 1);
  end
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (resetn && we) mem[wptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end
  // state registers; hard reset and the post-timeout flush clear the same state
  always_ff @(posedge clk) begin
    if (!resetn || sr_q) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
      to_q   <= '0;
      sr_q   <= 1'b0;
      pd_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      to_q   <= to_d;
      sr_q   <= sr_d;
      pd_q   <= pd_d;
    end
  end
endmodule

// File: tb/tb_router_destin_port.sv
// tb_router_destin_port: directed self-checking bench for router_destin_port
module tb_router_destin_port;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b;
  router_destin_port_if #(.WIDTH(8)) bus ();
  router_destin_port #(.WIDTH(8), .DEPTH(16), .TIMEOUT(30)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    step();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask
  initial begin
    logic [7:0] pkt [5];
    logic [7:0] pkt2 [4];
    pkt  = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h1F};
    pkt2 = '{8'h09, 8'hA1, 8'hA2, 8'hAB};
    bus.write_enb = 1'b1;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'hAA;
    bus.read_enb  = 1'b0;
    step(2);
    chk("rst_data", bus.data_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_soft", bus.soft_reset, 0);
    chk("rst_done", bus.pkt_done, 0);
    bus.write_enb = 1'b0;
    resetn = 1'b1;
    step();
    chk("post_rst_valid", bus.valid_out, 0);
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    chk("pkt_valid", bus.valid_out, 1);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pkt_data", bus.data_out, pkt[i]);
      chk("pkt_done", bus.pkt_done, i == 4);
    end
    chk("pkt_empty", bus.valid_out, 0);
    step();
    chk("empty_read_hold", bus.data_out, 8'h1F);
    chk("empty_read_done", bus.pkt_done, 0);
    bus.read_enb = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        wr(8'(f * 8'h40 + i + 1), 1'b0);
        chk("fill_full", bus.full, i == 15);
      end
      wr(8'h99, 1'b0);
      chk("over_full", bus.full, 1);
      bus.read_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
        step();
        chk("fill_data", bus.data_out, f * 8'h40 + i + 1);
      end
      chk("fill_empty", bus.valid_out, 0);
      bus.read_enb = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      wr(8'h80 + 8'(i), 1'b0);
      q.push_back(8'h80 + 8'(i));
    end
    bus.read_enb = 1'b1;
    bus.write_enb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'h90 + 8'(i);
      q.push_back(8'h90 + 8'(i));
      exp_b = q.pop_front();
      step();
      chk("sim_data", bus.data_out, exp_b);
      chk("sim_valid", bus.valid_out, 1);
      chk("sim_full", bus.full, 0);
    end
    bus.write_enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_b = q.pop_front();
      step();
      chk("drain_data", bus.data_out, exp_b);
    end
    chk("drain_empty", bus.valid_out, 0);
    bus.read_enb = 1'b0;
    wr(8'h5A, 1'b0);
    for (int k = 2; k <= 29; k++) begin
      step();
      chk("to_quiet", bus.soft_reset, 0);
    end
    step();
    chk("to_pulse", bus.soft_reset, 1);
    chk("to_pulse_valid", bus.valid_out, 1);
    bus.write_enb = 1'b1;
    bus.data_in = 8'h77;
    step();
    bus.write_enb = 1'b0;
    chk("to_pulse_end", bus.soft_reset, 0);
    chk("flush_valid", bus.valid_out, 0);
    chk("flush_data", bus.data_out, 0);
    step();
    chk("flush_write_lost", bus.valid_out, 0);
    wr(8'h5B, 1'b0);
    step(28);
    chk("rep_no_soft_pre", bus.soft_reset, 0);
    bus.read_enb = 1'b1;
    step();
    bus.read_enb = 1'b0;
    chk("rep_data", bus.data_out, 8'h5B);
    chk("rep_no_soft", bus.soft_reset, 0);
    step(3);
    chk("rep_no_soft_late", bus.soft_reset, 0);
    wr(8'h0D, 1'b1);
    wr(8'h11, 1'b0);
    bus.read_enb = 1'b1;
    step(2);
    bus.read_enb = 1'b0;
    chk("mid_data", bus.data_out, 8'h11);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_data", bus.data_out, 0);
    chk("mid_rst_valid", bus.valid_out, 0);
    for (int i = 0; i < 4; i++) wr(pkt2[i], i == 0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pkt2_data", bus.data_out, pkt2[i]);
      chk("pkt2_done", bus.pkt_done, i == 3);
    end
    bus.read_enb = 1'b0;
    step();
    chk("pkt2_done_end", bus.pkt_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/router_destin_port.md
Name: router_destin_port

Overview:
- One of three output ports of the 1x3 router.
- Buffers packet bytes routed to one destination in a 16-entry FIFO and presents them on the destination interface (data_out / valid_out / read_enb).
- Tracks packet boundaries so it can flag the parity byte.
- Flushes itself (soft reset) when the destination stops reading for TIMEOUT cycles.
- Written by the router FSM on the write side; read by the destination agent.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 16, FIFO entries; power of two.
- TIMEOUT, 30, consecutive unread cycles with valid_out high before soft reset.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset.
- write_enb  input  1  write request from router FSM.
- lfd_state  input  1  qualifies the byte being written as a packet header.
- data_in  input  WIDTH  byte to write.
- read_enb  input  1  read request from destination.
- data_out  output  WIDTH  registered read data.
- valid_out  output  1  FIFO non-empty.
- full  output  1  FIFO holds DEPTH entries.
- soft_reset  output  1  one-cycle flush pulse on timeout.
- pkt_done  output  1  one-cycle pulse; data_out holds the packet's last (parity) byte.

Behaviour:
- Storage and pointers:
  - Storage is DEPTH x (WIDTH+1); the extra bit stores lfd_state.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full = pointer MSBs differ and lower bits equal.
  - empty = pointers equal.
  - valid_out = ~empty, combinational from registered pointers.
- Reset (resetn low at posedge): pointers, occupancy, packet counter and timeout counter cleared; data_out=0, soft_reset=0, pkt_done=0, valid_out=0, full=0. Reset overrides everything else.
- Write: at posedge, if write_enb && !full, store {lfd_state, data_in} and advance the write pointer. A write while full is dropped silently, even if a read happens in the same cycle.
- Read:
  - At posedge, if read_enb && !empty, data_out <= entry data and the read pointer advances.
  - Latency: data appears the cycle after read_enb is sampled.
  - A read while empty is ignored and data_out holds its value.
- Simultaneous read and write when not full and not empty: both occur; occupancy is unchanged.
- Packet counter (internal, 7 bits):
  - On reading an entry with the lfd bit set, load header[7:2] + 1 (payload plus parity).
  - On reading a non-header entry with counter > 0, decrement.
  - pkt_done is registered: it asserts in the cycle data_out shows the byte that takes the counter 1 -> 0, then deasserts.
  - A header read while the counter is nonzero reloads the counter (truncated packet); no pkt_done is issued for the old packet.
- Timeout:
  - The counter increments each cycle with valid_out=1 && read_enb=0; it clears whenever valid_out=0 or read_enb=1.
  - When the counter reaches TIMEOUT-1 and the condition still holds, soft_reset pulses for one cycle. The pulse is registered, so it is high in cycle TIMEOUT counted from the first unread cycle.
- Soft flush: in the cycle after a soft_reset pulse (one-cycle flush), pointers, packet counter and timeout counter clear, and data_out=0.
  - A write in the flush cycle is discarded; flush wins.
  - A read in the flush cycle is ignored.
- resetn low while soft_reset is high: soft_reset clears immediately at that edge.

Test Plan:
- Reset: drive resetn=0 for 2 cycles with write_enb=1 -> all outputs 0, valid_out=0.
- Single packet: write header 0x0D (len 3, addr 1, lfd=1), then 0x11, 0x22, 0x33, parity 0x1F; then hold read_enb=1 -> data_out sequence 0x0D,0x11,0x22,0x33,0x1F on consecutive cycles, each one cycle after its read; pkt_done=1 only with 0x1F; valid_out falls after the fifth read.
- Full: write 17 bytes without reading -> full=1 after the 16th write; 17th byte absent; 16 reads return bytes 1-16; wrap-around verified by a second fill.
- Simultaneous: with 8 entries, assert read_enb and write_enb together for 10 cycles -> occupancy stays 8, order preserved, full/valid_out unchanged.
- Timeout: write 1 byte, hold read_enb=0 -> soft_reset high exactly in cycle 30, one cycle wide; next cycle valid_out=0 and data_out=0. Repeat with read_enb pulsed at cycle 29 -> no soft_reset.
- Edge cases:
  - Write during the flush cycle is lost.
  - Read on empty leaves data_out unchanged.
  - resetn low mid-packet clears pkt counter; the next packet's pkt_done is still correct.
